ts_mac_sched: RTL

//  Sequencer for the time-shared symmetric FIR, the pulse-shaping / matched filter datapath.

---
 rtl/ts_mac_sched.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ts_mac_sched.sv
// Sequencer for the time-shared symmetric FIR. Each sample strobe starts a schedule:
// one delay-line shift, SLOTS multiplier-bank slots over the tap pairs, and one
// output-register load. A strobe arriving before the MAC slots finish aborts the
// running schedule, restarts it for the new sample and sets a sticky overrun flag.
module ts_mac_sched #(
    parameter int  N_TAPS  = 21,
    parameter int  N_MULTS = 6,
    localparam int N_PAIRS = (N_TAPS + 1) / 2,
    localparam int SLOTS   = (N_PAIRS + N_MULTS - 1) / N_MULTS,
    localparam int PW      = $clog2(N_PAIRS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sam_clk_en,
    input  logic               sym_clk_en,
    output logic               shift_en,
    output logic               sym_sel,
    output logic               acc_clr,
    output logic               mac_en,
    output logic [PW-1:0]      pair_base,
    output logic [N_MULTS-1:0] lane_en,
    output logic               y_load,
    output logic               busy,
    output logic               overrun_err
);

    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, MAC, DUMP} state_t;

    state_t             state, nxt_state;
    logic [SW-1:0]      slot, nxt_slot;
    logic               nxt_sym_sel;
    logic               nxt_overrun;
    logic [PW-1:0]      nxt_pair_base;
    logic [N_MULTS-1:0] nxt_lane_en;
    logic [31:0]        base_full;

    // Next state, slot and output decode; outputs are registered from the next state
    // so every output reflects the state the FSM is in during that cycle.
    always_comb begin
        nxt_state     = state;
        nxt_slot      = slot;
        nxt_sym_sel   = 1'b0;
        nxt_overrun   = overrun_err;
        nxt_pair_base = '0;
        nxt_lane_en   = '0;
        base_full     = '0;

        case (state)
            IDLE: begin
                if (sam_clk_en) begin
                    nxt_state   = SHIFT;
                    nxt_sym_sel = sym_clk_en;
                end
            end
            SHIFT: begin
                if (sam_clk_en) begin
                    nxt_state   = SHIFT;
                    nxt_sym_sel = sym_clk_en;
                    nxt_overrun = 1'b1;
                end else begin
                    nxt_state = MAC;
                    nxt_slot  = '0;
                end
            end
            MAC: begin
                if (sam_clk_en) begin
                    nxt_state   = SHIFT;
                    nxt_sym_sel = sym_clk_en;
                    nxt_overrun = 1'b1;
                end else if (slot == LAST_SLOT) begin
                    nxt_state = DUMP;
                end else begin
                    nxt_slot = slot + SW'(1);
                end
            end
            DUMP: begin
                // A strobe here is the normal full-rate case, not an overrun.
                if (sam_clk_en) begin
                    nxt_state   = SHIFT;
                    nxt_sym_sel = sym_clk_en;
                end else begin
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase

        if (nxt_state == MAC) begin
            base_full     = 32'(nxt_slot) * 32'(N_MULTS);
            nxt_pair_base = base_full[PW-1:0];
            for (int i = 0; i < N_MULTS; i++) begin
                nxt_lane_en[i] = (base_full + 32'(i)) < 32'(N_PAIRS);
            end
        end
    end

    // State, slot counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            slot        <= '0;
            shift_en    <= 1'b0;
            sym_sel     <= 1'b0;
            acc_clr     <= 1'b0;
            mac_en      <= 1'b0;
            pair_base   <= '0;
            lane_en     <= '0;
            y_load      <= 1'b0;
            busy        <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state       <= nxt_state;
            slot        <= nxt_slot;
            shift_en    <= (nxt_state == SHIFT);
            sym_sel     <= nxt_sym_sel;
            acc_clr     <= (nxt_state == MAC) && (nxt_slot == '0);
            mac_en      <= (nxt_state == MAC);
            pair_base   <= nxt_pair_base;
            lane_en     <= nxt_lane_en;
            y_load      <= (nxt_state == DUMP);
            busy        <= (nxt_state != IDLE);
            overrun_err <= nxt_overrun;
        end
    end

endmodule
